// File: rtl/uart_pkg.sv
// Shared definitions for the UART MMIO controller.
// Holds the CPU-visible register addresses, the CON register bit positions
// and the TX handshake state encoding.
package uart_pkg;

    localparam logic [31:0] UART_ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] UART_ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] UART_ADDR_CON = 32'h4000_0020;

    localparam int CON_TX_IRQ_EN = 0;
    localparam int CON_RX_IRQ_EN = 1;
    localparam int CON_TX_BUSY   = 2;
    localparam int CON_RX_AVAIL  = 3;
    localparam int CON_OVERRUN   = 4;
    localparam int CON_TX_DONE   = 5;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_START     = 2'd1,
        TX_WAIT_DONE = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO for the UART controller.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_push, i_data    write request and byte (dropped when full unless popping)
//   i_pop             read request (ignored when empty)
//   o_data            current head entry (stale when empty)
//   o_full, o_empty   occupancy flags
//   o_count           number of stored entries
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE        = (AW + 1)'(1);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full  = (r_count == FULL_COUNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + ONE;
                2'b01:   r_count <= r_count - ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries
    // are valid, so clearing the array would only cost reset fan-out.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped bus controller between the CPU data bus and a UART
// receiver/sender pair.
// Ports:
//   sysclk, reset          system clock, asynchronous active-high reset
//   addr, wdata            CPU address and write data
//   mem_write, mem_read    CPU strobes (write acts at posedge, RXD read pops)
//   rdata                  combinational read data for addr
//   rx_byte, rx_status     receiver byte and frame-complete level (async)
//   tx_byte, tx_en         byte and start request to the sender
//   tx_status              sender idle level (async, 1 = idle)
//   irq                    registered interrupt request
module uart_mmio_ctrl
    import uart_pkg::*;
#(
    parameter logic [31:0] ADDR_TXD = UART_ADDR_TXD,
    parameter logic [31:0] ADDR_RXD = UART_ADDR_RXD,
    parameter logic [31:0] ADDR_CON = UART_ADDR_CON,
    parameter int          RX_DEPTH = 4
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [31:0] rdata,
    input  logic [7:0]  rx_byte,
    input  logic        rx_status,
    output logic [7:0]  tx_byte,
    output logic        tx_en,
    input  logic        tx_status,
    output logic        irq
);

    // ---------------- status synchronisers ----------------
    logic       r_rx_meta;
    logic       r_rx_sync;
    logic       r_rx_prev;
    logic [1:0] r_rx_fill;
    logic       r_tx_meta;
    logic       r_tx_sync;
    logic       w_rx_rise;
    logic       w_tx_status_s;

    // The edge detector starts "high" and only tracks the synchronised level
    // once the two-flop pipeline holds real samples, so an rx_status that is
    // already high when reset drops is not mistaken for a new frame.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b0;
            r_rx_sync <= 1'b0;
            r_rx_prev <= 1'b1;
            r_rx_fill <= 2'b00;
            r_tx_meta <= 1'b1;
            r_tx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx_status;
            r_rx_sync <= r_rx_meta;
            r_rx_fill <= {r_rx_fill[0], 1'b1};
            if (r_rx_fill[1]) r_rx_prev <= r_rx_sync;
            r_tx_meta <= tx_status;
            r_tx_sync <= r_tx_meta;
        end
    end

    assign w_rx_rise     = r_rx_sync & ~r_rx_prev;
    assign w_tx_status_s = r_tx_sync;

    // ---------------- address decode ----------------
    logic w_sel_txd;
    logic w_sel_rxd;
    logic w_sel_con;
    logic w_txd_wr;
    logic w_con_wr;
    logic w_rxd_rd;

    assign w_sel_txd = (addr == ADDR_TXD);
    assign w_sel_rxd = (addr == ADDR_RXD);
    assign w_sel_con = (addr == ADDR_CON);
    assign w_txd_wr  = mem_write & w_sel_txd;
    assign w_con_wr  = mem_write & w_sel_con;
    assign w_rxd_rd  = mem_read & w_sel_rxd;

    // ---------------- RX FIFO ----------------
    logic [7:0]                  w_rx_head;
    logic                        w_rx_full;
    logic                        w_rx_empty;
    logic [$clog2(RX_DEPTH):0]   w_rx_count;
    logic                        w_rx_avail;
    logic                        w_overrun_set;

    uart_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .i_clk   (sysclk),
        .i_rst   (reset),
        .i_push  (w_rx_rise),
        .i_pop   (w_rxd_rd),
        .i_data  (rx_byte),
        .o_data  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    assign w_rx_avail = ~w_rx_empty;
    // A byte is lost only when full and no pop makes room in the same cycle.
    assign w_overrun_set = w_rx_rise & w_rx_full & ~w_rxd_rd;

    // ---------------- TX handshake FSM ----------------
    tx_state_t r_state;
    tx_state_t w_state_next;
    logic      w_tx_latch;
    logic      w_tx_done_set;
    logic      r_tx_en;
    logic [7:0] r_tx_byte;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) r_state <= TX_IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next  = r_state;
        w_tx_latch    = 1'b0;
        w_tx_done_set = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (w_txd_wr) begin
                    w_tx_latch   = 1'b1;
                    w_state_next = TX_START;
                end
            end
            TX_START: begin
                if (!w_tx_status_s) w_state_next = TX_WAIT_DONE;
            end
            TX_WAIT_DONE: begin
                if (w_tx_status_s) begin
                    w_tx_done_set = 1'b1;
                    w_state_next  = TX_IDLE;
                end
            end
            default: w_state_next = TX_IDLE;
        endcase
    end

    // TXD writes outside IDLE never reach w_tx_latch, so the byte is frozen
    // for the whole transfer.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_tx_en   <= 1'b0;
            r_tx_byte <= 8'h00;
        end else begin
            r_tx_en <= (w_state_next == TX_START);
            if (w_tx_latch) r_tx_byte <= wdata[7:0];
        end
    end

    assign tx_en   = r_tx_en;
    assign tx_byte = r_tx_byte;

    // ---------------- CON register and interrupt ----------------
    logic r_tx_irq_en;
    logic r_rx_irq_en;
    logic r_overrun;
    logic r_tx_done;
    logic r_irq;
    logic w_tx_busy;

    assign w_tx_busy = (r_state != TX_IDLE);

    // Sticky flags: a new event in the same cycle as a W1C wins.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_tx_irq_en <= 1'b0;
            r_rx_irq_en <= 1'b0;
            r_overrun   <= 1'b0;
            r_tx_done   <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (w_con_wr) begin
                r_tx_irq_en <= wdata[CON_TX_IRQ_EN];
                r_rx_irq_en <= wdata[CON_RX_IRQ_EN];
            end
            if (w_overrun_set)                        r_overrun <= 1'b1;
            else if (w_con_wr && wdata[CON_OVERRUN])  r_overrun <= 1'b0;
            if (w_tx_done_set)                        r_tx_done <= 1'b1;
            else if (w_con_wr && wdata[CON_TX_DONE])  r_tx_done <= 1'b0;
            r_irq <= (r_rx_irq_en & w_rx_avail) |
                     (r_tx_irq_en & r_tx_done)  |
                     (r_rx_irq_en & r_overrun);
        end
    end

    assign irq = r_irq;

    // ---------------- read mux ----------------
    always_comb begin
        rdata = 32'h0;
        if (w_sel_txd) begin
            rdata = {24'h0, r_tx_byte};
        end else if (w_sel_rxd) begin
            rdata = w_rx_empty ? 32'h0 : {24'h0, w_rx_head};
        end else if (w_sel_con) begin
            rdata = {26'h0, r_tx_done, r_overrun, w_rx_avail,
                     w_tx_busy, r_rx_irq_en, r_tx_irq_en};
        end
    end

    // Upper write-data bits and the FIFO fill level have no register behind them.
    logic w_unused;
    assign w_unused = ^{wdata[31:8], w_rx_count};

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed testbench for uart_mmio_ctrl: RX path, FIFO overflow and
// full push+pop, TX handshake, busy-write rejection, interrupts and
// reset in the middle of a transfer.
module tb_uart_mmio_ctrl;
    import uart_pkg::*;

    logic        sysclk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [31:0] rdata;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_status = 1'b0;
    logic [7:0]  tx_byte;
    logic        tx_en;
    logic        tx_status = 1'b1;
    logic        irq;

    int errors = 0;
    int checks = 0;

    uart_mmio_ctrl #(.RX_DEPTH(4)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .addr      (addr),
        .wdata     (wdata),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .rdata     (rdata),
        .rx_byte   (rx_byte),
        .rx_status (rx_status),
        .tx_byte   (tx_byte),
        .tx_en     (tx_en),
        .tx_status (tx_status),
        .irq       (irq)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wdata = d;
        mem_write = 1'b1;
        tick(1);
        mem_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        mem_read = 1'b1;
        #1 d = rdata;
        tick(1);
        mem_read = 1'b0;
    endtask

    // Look at a register without a read strobe (no FIFO pop).
    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1 d = rdata;
    endtask

    // One receiver frame: rx_status high for 4 cycles, then low for 4.
    task automatic send_rx(input logic [7:0] b);
        rx_byte = b;
        rx_status = 1'b1;
        tick(4);
        rx_status = 1'b0;
        tick(4);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        tick(3);
        checks++;
        if (tx_en !== 1'b0) begin
            errors++; $display("FAIL reset_tx_en_held: got %b expected 0", tx_en);
        end
        reset = 1'b0;
        tick(2);
        peek(UART_ADDR_CON, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL reset_con: got %h expected 00000000", d);
        end
        peek(UART_ADDR_RXD, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL reset_rxd: got %h expected 00000000", d);
        end
        checks++;
        if (tx_byte !== 8'h00) begin
            errors++; $display("FAIL reset_tx_byte: got %h expected 00", tx_byte);
        end
        checks++;
        if (tx_en !== 1'b0) begin
            errors++; $display("FAIL reset_tx_en: got %b expected 0", tx_en);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL reset_irq: got %b expected 0", irq);
        end
    endtask

    task automatic test_rx_single;
        logic [31:0] d;
        rx_byte = 8'hA5;
        rx_status = 1'b1;
        tick(2);
        peek(UART_ADDR_CON, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL rx_single_early: got %h expected 00000000", d);
        end
        tick(1);
        peek(UART_ADDR_CON, d);
        checks++;
        if (d !== 32'h08) begin
            errors++; $display("FAIL rx_single_avail: got %h expected 00000008", d);
        end
        tick(17);
        rx_status = 1'b0;
        tick(4);
        cpu_read(UART_ADDR_RXD, d);
        checks++;
        if (d !== 32'h0000_00A5) begin
            errors++; $display("FAIL rx_single_data: got %h expected 000000a5", d);
        end
        peek(UART_ADDR_CON, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL rx_single_con_after: got %h expected 00000000", d);
        end
        cpu_read(UART_ADDR_RXD, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL rx_single_one_push: got %h expected 00000000", d);
        end
    endtask

    task automatic test_rx_overflow;
        logic [31:0] d;
        for (int i = 1; i <= 5; i++) send_rx(8'(i));
        peek(UART_ADDR_CON, d);
        checks++;
        if (d !== 32'h18) begin
            errors++; $display("FAIL overflow_con: got %h expected 00000018", d);
        end
        for (int i = 1; i <= 4; i++) begin
            cpu_read(UART_ADDR_RXD, d);
            checks++;
            if (d !== 32'(i)) begin
                errors++; $display("FAIL overflow_data_%0d: got %h expected %h", i, d, 32'(i));
            end
        end
        cpu_read(UART_ADDR_RXD, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL overflow_empty_read: got %h expected 00000000", d);
        end
        peek(UART_ADDR_CON, d);
        checks++;
        if (d !== 32'h10) begin
            errors++; $display("FAIL overflow_sticky: got %h expected 00000010", d);
        end
        cpu_write(UART_ADDR_CON, 32'h10);
        peek(UART_ADDR_CON, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL overflow_w1c: got %h expected 00000000", d);
        end
    endtask

    // Push lands on a full FIFO in the same cycle as a pop: both happen.
    task automatic test_full_push_pop;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) send_rx(8'h11 + 8'(i));
        rx_byte = 8'h15;
        rx_status = 1'b1;
        tick(2);
        addr = UART_ADDR_RXD;
        mem_read = 1'b1;
        #1 d = rdata;
        checks++;
        if (d !== 32'h11) begin
            errors++; $display("FAIL fullpp_head: got %h expected 00000011", d);
        end
        tick(1);
        mem_read = 1'b0;
        peek(UART_ADDR_CON, d);
        checks++;
        if (d !== 32'h08) begin
            errors++; $display("FAIL fullpp_no_overrun: got %h expected 00000008", d);
        end
        rx_status = 1'b0;
        tick(4);
        for (int i = 0; i < 4; i++) begin
            cpu_read(UART_ADDR_RXD, d);
            checks++;
            if (d !== 32'h12 + 32'(i)) begin
                errors++; $display("FAIL fullpp_data_%0d: got %h expected %h", i, d, 32'h12 + 32'(i));
            end
        end
        peek(UART_ADDR_CON, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL fullpp_drained: got %h expected 00000000", d);
        end
    endtask

    task automatic test_tx_handshake;
        logic [31:0] d;
        int n;
        int highs;
        cpu_write(UART_ADDR_TXD, 32'h3C);
        checks++;
        if (tx_en !== 1'b1) begin
            errors++; $display("FAIL tx_start_en: got %b expected 1", tx_en);
        end
        checks++;
        if (tx_byte !== 8'h3C) begin
            errors++; $display("FAIL tx_start_byte: got %h expected 3c", tx_byte);
        end
        peek(UART_ADDR_CON, d);
        checks++;
        if (d !== 32'h04) begin
            errors++; $display("FAIL tx_start_busy: got %h expected 00000004", d);
        end
        tick(10);
        checks++;
        if (tx_en !== 1'b1) begin
            errors++; $display("FAIL tx_en_hold: got %b expected 1", tx_en);
        end
        tx_status = 1'b0;
        n = 0;
        while (tx_en === 1'b1 && n < 6) begin
            tick(1);
            n++;
        end
        checks++;
        if (tx_en !== 1'b0) begin
            errors++; $display("FAIL tx_en_drop: got %b expected 0 within 6 cycles", tx_en);
        end
        peek(UART_ADDR_CON, d);
        checks++;
        if (d !== 32'h04) begin
            errors++; $display("FAIL tx_wait_busy: got %h expected 00000004", d);
        end
        // Write while busy must be ignored.
        cpu_write(UART_ADDR_TXD, 32'h77);
        highs = 0;
        repeat (10) begin
            if (tx_en === 1'b1) highs++;
            tick(1);
        end
        checks++;
        if (tx_byte !== 8'h3C) begin
            errors++; $display("FAIL tx_busy_byte: got %h expected 3c", tx_byte);
        end
        checks++;
        if (highs !== 0) begin
            errors++; $display("FAIL tx_busy_no_pulse: got %0d high cycles expected 0", highs);
        end
        tick(80);
        tx_status = 1'b1;
        n = 0;
        peek(UART_ADDR_CON, d);
        while (d[CON_TX_BUSY] === 1'b1 && n < 6) begin
            tick(1);
            peek(UART_ADDR_CON, d);
            n++;
        end
        checks++;
        if (d !== 32'h20) begin
            errors++; $display("FAIL tx_done_con: got %h expected 00000020", d);
        end
        highs = 0;
        repeat (5) begin
            if (tx_en === 1'b1) highs++;
            tick(1);
        end
        checks++;
        if (highs !== 0) begin
            errors++; $display("FAIL tx_done_no_restart: got %0d high cycles expected 0", highs);
        end
        cpu_write(UART_ADDR_CON, 32'h20);
        peek(UART_ADDR_CON, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL tx_done_w1c: got %h expected 00000000", d);
        end
    endtask

    task automatic test_irq;
        logic [31:0] d;
        cpu_write(UART_ADDR_CON, 32'h03);
        tick(1);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_idle: got %b expected 0", irq);
        end
        send_rx(8'h55);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_rx: got %b expected 1", irq);
        end
        cpu_read(UART_ADDR_RXD, d);
        checks++;
        if (d !== 32'h55) begin
            errors++; $display("FAIL irq_rx_data: got %h expected 00000055", d);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_registered: got %b expected 1", irq);
        end
        tick(1);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_rx_clear: got %b expected 0", irq);
        end
        cpu_write(UART_ADDR_TXD, 32'h99);
        tick(3);
        tx_status = 1'b0;
        tick(5);
        tx_status = 1'b1;
        tick(5);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_tx: got %b expected 1", irq);
        end
        peek(UART_ADDR_CON, d);
        checks++;
        if (d !== 32'h23) begin
            errors++; $display("FAIL irq_tx_con: got %h expected 00000023", d);
        end
        cpu_write(UART_ADDR_CON, 32'h23);
        tick(1);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_tx_clear: got %b expected 0", irq);
        end
        peek(UART_ADDR_CON, d);
        checks++;
        if (d !== 32'h03) begin
            errors++; $display("FAIL irq_enables_kept: got %h expected 00000003", d);
        end
        cpu_write(UART_ADDR_CON, 32'h00);
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        send_rx(8'hC1);
        send_rx(8'hC2);
        cpu_write(UART_ADDR_TXD, 32'hAB);
        peek(UART_ADDR_CON, d);
        checks++;
        if (d !== 32'h0C) begin
            errors++; $display("FAIL rmid_pre_con: got %h expected 0000000c", d);
        end
        rx_byte = 8'hC3;
        rx_status = 1'b1;
        tick(1);
        reset = 1'b1;
        #1;
        checks++;
        if (tx_en !== 1'b0) begin
            errors++; $display("FAIL rmid_tx_en: got %b expected 0", tx_en);
        end
        tick(2);
        reset = 1'b0;
        peek(UART_ADDR_CON, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL rmid_con: got %h expected 00000000", d);
        end
        peek(UART_ADDR_RXD, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL rmid_rxd: got %h expected 00000000", d);
        end
        tick(8);
        peek(UART_ADDR_CON, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL rmid_no_stale_push: got %h expected 00000000", d);
        end
        rx_status = 1'b0;
        tick(4);
        rx_status = 1'b1;
        tick(4);
        peek(UART_ADDR_CON, d);
        checks++;
        if (d !== 32'h08) begin
            errors++; $display("FAIL rmid_new_frame: got %h expected 00000008", d);
        end
        cpu_read(UART_ADDR_RXD, d);
        checks++;
        if (d !== 32'hC3) begin
            errors++; $display("FAIL rmid_new_data: got %h expected 000000c3", d);
        end
        rx_status = 1'b0;
        tick(4);
    endtask

    initial begin
        test_reset();
        test_rx_single();
        test_rx_overflow();
        test_full_push_pop();
        test_tx_handshake();
        test_irq();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
